// File: rtl/dmem_responder.sv
// Data-memory responder: combinational core loads, posted core stores through a
// small store buffer drained in the background, and a host port that outranks the drain.
module dmem_responder #(
    parameter int unsigned WORD_BITWIDTH = 32,
    parameter int unsigned ADDR_BITS     = 10,
    parameter int unsigned SB_DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           data_ce_i,
    input  logic                           data_we_i,
    input  logic [31:0]                    data_addr_i,
    input  logic [WORD_BITWIDTH-1:0]       data_i,
    output logic [WORD_BITWIDTH-1:0]       data_o,
    input  logic                           host_req,
    input  logic                           host_we,
    input  logic [ADDR_BITS-1:0]           host_addr,
    input  logic [WORD_BITWIDTH-1:0]       host_wdata,
    output logic                           host_gnt,
    output logic                           host_ack,
    output logic [WORD_BITWIDTH-1:0]       host_rdata,
    output logic [$clog2(SB_DEPTH):0]      sb_count,
    output logic                           sb_empty
);

    localparam int unsigned PTR_W     = $clog2(SB_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned RAM_DEPTH = 2 ** ADDR_BITS;

    logic [WORD_BITWIDTH-1:0] ram_q     [RAM_DEPTH];
    logic [ADDR_BITS-1:0]     sb_idx_q  [SB_DEPTH];
    logic [WORD_BITWIDTH-1:0] sb_data_q [SB_DEPTH];

    logic [PTR_W-1:0]         head_q, head_d;
    logic [PTR_W-1:0]         tail_q, tail_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     host_ack_q, host_ack_d;
    logic [WORD_BITWIDTH-1:0] host_rdata_q, host_rdata_d;

    logic [ADDR_BITS-1:0]     core_idx;
    logic                     core_hit;
    logic [WORD_BITWIDTH-1:0] core_hit_data;
    logic                     host_hit;
    logic [WORD_BITWIDTH-1:0] host_hit_data;
    logic [PTR_W-1:0]         pos;

    logic                     push;
    logic                     pop;
    logic                     ram_we;
    logic [ADDR_BITS-1:0]     ram_waddr;
    logic [WORD_BITWIDTH-1:0] ram_wdata;
    logic                     unused_addr_bits;

    assign core_idx         = data_addr_i[ADDR_BITS+1:2];
    assign unused_addr_bits = ^{data_addr_i[31:ADDR_BITS+2], data_addr_i[1:0]};

    // Youngest-match search: walking oldest to youngest lets the last hit win.
    always_comb begin
        core_hit      = 1'b0;
        core_hit_data = '0;
        host_hit      = 1'b0;
        host_hit_data = '0;
        pos           = head_q;
        for (int k = 0; k < SB_DEPTH; k++) begin
            pos = head_q + PTR_W'(k);
            if (CNT_W'(k) < count_q) begin
                if (sb_idx_q[pos] == core_idx) begin
                    core_hit      = 1'b1;
                    core_hit_data = sb_data_q[pos];
                end
                if (sb_idx_q[pos] == host_addr) begin
                    host_hit      = 1'b1;
                    host_hit_data = sb_data_q[pos];
                end
            end
        end
    end

    always_comb begin
        data_o = '0;
        if (data_ce_i) begin
            data_o = core_hit ? core_hit_data : ram_q[core_idx];
        end
    end

    // A host write must not land before an older buffered store to the same word.
    assign host_gnt = host_req && (count_q < CNT_W'(SB_DEPTH)) && !(host_we && host_hit);
    assign push     = data_we_i;
    assign pop      = (count_q != '0) && !host_gnt;

    // Shared RAM write port; nothing lands in the array during reset.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = sb_idx_q[head_q];
        ram_wdata = sb_data_q[head_q];
        if (!rst) begin
            if (host_gnt) begin
                ram_we    = host_we;
                ram_waddr = host_addr;
                ram_wdata = host_wdata;
            end else if (pop) begin
                ram_we    = 1'b1;
            end
        end
    end

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        host_ack_d   = host_gnt;
        host_rdata_d = host_rdata_q;
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (host_gnt && !host_we) begin
            host_rdata_d = host_hit ? host_hit_data : ram_q[host_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    // Storage arrays carry no reset; validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            sb_idx_q[tail_q]  <= core_idx;
            sb_data_q[tail_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_waddr] <= ram_wdata;
        end
    end

    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;
    assign sb_count   = count_q;
    assign sb_empty   = (count_q == '0);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table with hand-derived expectations, host
// acknowledgements scored through a queue, plus a bounded host-write wait sequence.
module tb_dmem_responder;

    localparam int unsigned W  = 32;
    localparam int unsigned AB = 10;
    localparam int unsigned SD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          data_ce_i, data_we_i;
    logic [31:0]   data_addr_i;
    logic [W-1:0]  data_i, data_o;
    logic          host_req, host_we, host_gnt, host_ack;
    logic [AB-1:0] host_addr;
    logic [W-1:0]  host_wdata, host_rdata;
    logic [2:0]    sb_count;
    logic          sb_empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WORD_BITWIDTH(W), .ADDR_BITS(AB), .SB_DEPTH(SD)) dut (
        .clk(clk), .rst(rst),
        .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_i(data_i), .data_o(data_o),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_ack(host_ack),
        .host_rdata(host_rdata), .sb_count(sb_count), .sb_empty(sb_empty)
    );

    typedef struct {
        logic        is_read;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        rst, ce, we;
        logic [31:0] addr, wd;
        logic        hreq, hwe;
        logic [9:0]  haddr;
        logic [31:0] hwd;
        logic [31:0] exp_do;
        logic        exp_gnt;
        logic [2:0]  exp_cnt;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic r, input logic ce, input logic we,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic hreq, input logic hwe, input logic [9:0] haddr,
                                input logic [31:0] hwd, input logic [31:0] exp_do,
                                input logic exp_gnt, input logic [2:0] exp_cnt,
                                input logic [31:0] exp_rd);
        vec_t v;
        v.rst = r; v.ce = ce; v.we = we; v.addr = addr; v.wd = wd;
        v.hreq = hreq; v.hwe = hwe; v.haddr = haddr; v.hwd = hwd;
        v.exp_do = exp_do; v.exp_gnt = exp_gnt; v.exp_cnt = exp_cnt; v.exp_rd = exp_rd;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // An ack is due exactly when the previous cycle left an expected grant in the queue.
    task automatic ack_check();
        exp_t e;
        check("host_ack", 32'(host_ack), 32'(sbq.size() != 0));
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            if (e.is_read) check("host_rdata", host_rdata, e.data);
        end
    endtask

    task automatic drive(input logic r, input logic ce, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic hreq, input logic hwe, input logic [9:0] haddr,
                         input logic [31:0] hwd);
        rst = r; data_ce_i = ce; data_we_i = we; data_addr_i = addr; data_i = wd;
        host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwd;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Occupancy bound: the buffer must never claim more than SB_DEPTH entries.
    always @(negedge clk) begin
        assert (sb_count <= 3'(SD))
        else begin
            errors++;
            $display("FAIL sb_count_overflow: got %0d limit %0d", sb_count, SD);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic prev_rst;
        logic granted;
        int   waits;

        // rst ce we addr wd | hreq hwe haddr hwd | exp_do gnt cnt rd
        add(0,0,0,32'h0,0, 1,1,3,32'h33,   0,1,0,0);
        add(0,0,0,32'h0,0, 1,1,7,32'h77,   0,1,0,0);
        add(0,0,0,32'h0,0, 1,1,9,32'h99,   0,1,0,0);
        add(0,0,0,32'h0,0, 1,1,20,32'h2020, 0,1,0,0);
        add(0,0,0,32'h0,0, 1,1,21,32'h2121, 0,1,0,0);
        add(0,0,0,32'h0,0, 1,1,22,32'h2222, 0,1,0,0);
        add(0,1,0,32'h54,0, 1,0,20,0,      32'h2121,1,0,32'h2020);
        // store then load through the buffer, then from RAM, then aliased address
        add(0,0,1,32'h10,32'hDEADBEEF, 0,0,0,0, 0,0,0,0);
        add(0,1,0,32'h10,0, 0,0,0,0,       32'hDEADBEEF,0,1,0);
        add(0,1,0,32'h10,0, 0,0,0,0,       32'hDEADBEEF,0,0,0);
        add(0,1,0,32'h80001013,0, 1,0,4,0, 32'hDEADBEEF,1,0,32'hDEADBEEF);
        // host read held while the buffer fills
        add(0,0,1,32'h04,32'h101, 1,0,3,0, 0,1,0,32'h33);
        add(0,0,1,32'h08,32'h102, 1,0,3,0, 0,1,1,32'h33);
        add(0,0,1,32'h0C,32'h103, 1,0,3,0, 0,1,2,32'h33);
        add(0,0,1,32'h10,32'h104, 1,0,3,0, 0,1,3,32'h103);
        add(0,0,1,32'h14,32'h105, 1,0,3,0, 0,0,4,0);
        add(0,1,0,32'h04,0, 1,0,3,0,       32'h101,0,4,0);
        add(0,0,0,32'h0,0, 1,0,3,0,        0,1,3,32'h103);
        add(0,1,0,32'h08,0, 0,0,0,0,       32'h102,0,3,0);
        add(0,1,0,32'h0C,0, 0,0,0,0,       32'h103,0,2,0);
        add(0,1,0,32'h14,0, 0,0,0,0,       32'h105,0,1,0);
        add(0,1,0,32'h14,0, 0,0,0,0,       32'h105,0,0,0);
        // duplicate index, youngest wins; same-cycle store invisible
        add(0,0,1,32'h1C,32'h11, 1,0,20,0, 0,1,0,32'h2020);
        add(0,1,1,32'h1C,32'h22, 1,0,20,0, 32'h11,1,1,32'h2020);
        add(0,1,0,32'h1C,0, 1,0,7,0,       32'h22,1,2,32'h22);
        add(0,1,0,32'h1C,0, 0,0,0,0,       32'h22,0,2,0);
        add(0,1,0,32'h1C,0, 0,0,0,0,       32'h22,0,1,0);
        add(0,1,0,32'h1C,0, 0,0,0,0,       32'h22,0,0,0);
        // host write blocked by a pending entry at the same index
        add(0,0,1,32'h24,32'h909, 1,0,20,0, 0,1,0,32'h2020);
        add(0,0,1,32'h28,32'hA0A, 1,0,20,0, 0,1,1,32'h2020);
        add(0,0,0,32'h0,0, 1,1,9,32'h9A,   0,0,2,0);
        add(0,0,0,32'h0,0, 1,1,9,32'h9A,   0,1,1,0);
        add(0,1,0,32'h24,0, 0,0,0,0,       32'h9A,0,1,0);
        add(0,1,0,32'h28,0, 0,0,0,0,       32'hA0A,0,0,0);
        // same-cycle host write and core store: core wins
        add(0,0,1,32'h0C,32'hBB, 1,1,3,32'hAA, 0,1,0,0);
        add(0,1,0,32'h0C,0, 0,0,0,0,       32'hBB,0,1,0);
        add(0,1,0,32'h0C,0, 1,0,3,0,       32'hBB,1,0,32'hBB);
        // reset discards pending stores
        add(0,0,1,32'h50,32'hE0, 1,0,3,0,  0,1,0,32'hBB);
        add(0,0,1,32'h54,32'hE1, 1,0,3,0,  0,1,1,32'hBB);
        add(0,0,1,32'h58,32'hE2, 1,0,3,0,  0,1,2,32'hBB);
        add(1,1,0,32'h50,0, 0,0,0,0,       32'hE0,0,3,0);
        add(0,1,0,32'h50,0, 0,0,0,0,       32'h2020,0,0,0);
        add(0,1,0,32'h54,0, 0,0,0,0,       32'h2121,0,0,0);
        add(0,1,0,32'h58,0, 0,0,0,0,       32'h2222,0,0,0);

        drive(1,0,0,0,0, 0,0,0,0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_sb_count", 32'(sb_count), 0);
        check("reset_sb_empty", 32'(sb_empty), 1);
        check("reset_host_ack", 32'(host_ack), 0);
        check("reset_host_rdata", host_rdata, 0);
        check("reset_data_o", data_o, 0);

        prev_rst = 1'b0;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].wd,
                  vecs[i].hreq, vecs[i].hwe, vecs[i].haddr, vecs[i].hwd);
            #1;
            ack_check();
            if (prev_rst) check($sformatf("v%0d_rdata_after_rst", i), host_rdata, 0);
            check($sformatf("v%0d_sb_count", i), 32'(sb_count), 32'(vecs[i].exp_cnt));
            check($sformatf("v%0d_sb_empty", i), 32'(sb_empty), 32'(vecs[i].exp_cnt == 0));
            check($sformatf("v%0d_host_gnt", i), 32'(host_gnt), 32'(vecs[i].exp_gnt));
            check($sformatf("v%0d_data_o", i), data_o, vecs[i].exp_do);
            if (vecs[i].exp_gnt) begin
                sbq.push_back('{is_read: !vecs[i].hwe, data: vecs[i].exp_rd});
            end
            prev_rst = vecs[i].rst;
            step();
        end

        // Two stores to word 30 pending; a held host write waits for both to drain.
        drive(0,0,1,32'h78,32'h300, 1,0,20,0);
        #1;
        ack_check();
        check("seq_gnt_a", 32'(host_gnt), 1);
        sbq.push_back('{is_read: 1'b1, data: 32'h2020});
        step();
        drive(0,0,1,32'h78,32'h301, 1,0,20,0);
        #1;
        ack_check();
        check("seq_gnt_b", 32'(host_gnt), 1);
        sbq.push_back('{is_read: 1'b1, data: 32'h2020});
        step();
        drive(0,0,0,0,0, 1,1,30,32'h3AA);
        granted = 1'b0;
        waits   = 0;
        for (int k = 0; k < 8 && !granted; k++) begin
            #1;
            ack_check();
            if (host_gnt) begin
                granted = 1'b1;
                sbq.push_back('{is_read: 1'b0, data: 32'h0});
            end else begin
                waits++;
            end
            step();
        end
        check("seq_write_granted", 32'(granted), 1);
        check("seq_write_wait_cycles", 32'(waits), 2);
        drive(0,1,0,32'h78,0, 0,0,0,0);
        #1;
        ack_check();
        check("seq_load_word30", data_o, 32'h3AA);
        check("seq_sb_count", 32'(sb_count), 0);
        step();
        #1;
        ack_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
